// File: rtl/sam_ifetch_queue.sv
// sam_ifetch_queue: instruction fetch front end with a credit-limited prefetch FIFO and branch flush.
module sam_ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        RN,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        br_en,
  input  logic [31:0] br_target,
  input  logic        id_ready,
  output logic        if_id_valid,
  output logic [31:0] if_id_ir,
  output logic [31:0] if_id_npc,
  output logic [31:0] fetch_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [31:0] ir_q [DEPTH];
  logic [31:0] npc_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count;
  logic inflight;
  logic [31:0] inflight_npc;
  logic push, pop;
  // Credit counts the in-flight slot but not a same-cycle pop, so the FIFO can never overflow.
  assign imem_req    = !RN && !br_en && ((count + (AW+1)'(inflight)) < FULL);
  assign imem_addr   = fetch_pc;
  assign if_id_valid = count != '0;
  assign if_id_ir    = if_id_valid ? ir_q[rd_ptr] : 32'd0;
  assign if_id_npc   = if_id_valid ? npc_q[rd_ptr] : 32'd0;
  assign push        = inflight && !br_en;
  assign pop         = if_id_valid && id_ready && !br_en;
  always_ff @(posedge clk) begin
    if (push) begin
      ir_q[wr_ptr]  <= imem_rdata;
      npc_q[wr_ptr] <= inflight_npc;
    end
  end
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      fetch_pc     <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      inflight     <= 1'b0;
      inflight_npc <= '0;
    end else if (br_en) begin
      fetch_pc <= br_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc     <= fetch_pc + 32'd1;
        inflight_npc <= fetch_pc + 32'd1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (!RN) assert (!(push && count == FULL));
  end
endmodule
